// File: rtl/ram_1p_fifo_ctrl_if.sv
// Push/pop handshake bundle for the single-port-RAM FIFO controller.
// slave is the FIFO side, master is the producer/consumer side.
interface ram_1p_fifo_ctrl_if #(
   parameter int unsigned Width = 32
) ();
   logic             wvalid;
   logic             wready;
   logic [Width-1:0] wdata;
   logic             rvalid;
   logic             rready;
   logic [Width-1:0] rdata;

   modport slave (
      input  wvalid,
      input  wdata,
      input  rready,
      output wready,
      output rvalid,
      output rdata
   );

   modport master (
      output wvalid,
      output wdata,
      output rready,
      input  wready,
      input  rvalid,
      input  rdata
   );
endinterface

// File: rtl/ram_1p_fifo_ctrl.sv
// FIFO controller storing entries in an external synchronous single-port RAM
// (read data one cycle after the request). A one-entry head register lets pops
// stream at one per cycle; total capacity is Depth + 1.
module ram_1p_fifo_ctrl #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 64,
   localparam int unsigned Aw = $clog2(Depth),
   localparam int unsigned Cw = $clog2(Depth + 3)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   ram_1p_fifo_ctrl_if.slave bus,
   output logic [Cw-1:0]    depth_o,
   output logic             ram_req_o,
   output logic             ram_write_o,
   output logic [Aw-1:0]    ram_addr_o,
   output logic [Width-1:0] ram_wdata_o,
   output logic [Width-1:0] ram_wmask_o,
   input  logic [Width-1:0] ram_rdata_i
);

   logic [Aw-1:0]    wr_ptr_q;
   logic [Aw-1:0]    rd_ptr_q;
   logic [Cw-1:0]    ram_cnt_q;
   logic             rd_pend_q;
   logic             out_full_q;
   logic [Width-1:0] out_q;

   logic flush;
   logic rvalid;
   logic pop;
   logic rd_go;
   logic wr_go;
   logic wready;

   function automatic logic [Aw-1:0] ptr_inc(logic [Aw-1:0] p);
      return (p == Aw'(Depth - 1)) ? '0 : p + Aw'(1);
   endfunction

   // Handshake and RAM-port arbitration; reads win so the head never starves.
   always_comb begin
      flush  = rst_i | clr_i;
      rvalid = out_full_q | rd_pend_q;
      pop    = rvalid & bus.rready & ~flush;
      rd_go  = ~flush & (ram_cnt_q != '0) & (~rvalid | pop);
      // Deliberately independent of wvalid so producers may wait on wready.
      wready = ~flush & (ram_cnt_q < Cw'(Depth)) & ~rd_go;
      wr_go  = bus.wvalid & wready;
   end

   assign bus.wready  = wready;
   assign bus.rvalid  = rvalid;
   // While a read is in flight the head shows the RAM data directly.
   assign bus.rdata   = out_full_q ? out_q : ram_rdata_i;

   assign ram_req_o   = rd_go | wr_go;
   assign ram_write_o = wr_go;
   assign ram_addr_o  = wr_go ? wr_ptr_q : rd_ptr_q;
   assign ram_wdata_o = bus.wdata;
   assign ram_wmask_o = '1;

   // Built from registered state only: no combinational path from any input.
   assign depth_o = ram_cnt_q + Cw'(out_full_q) + Cw'(rd_pend_q);

   // RAM pointers and RAM occupancy.
   always_ff @(posedge clk_i) begin
      if (flush) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ram_cnt_q <= '0;
      end else begin
         if (wr_go) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (rd_go) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (wr_go) begin
            ram_cnt_q <= ram_cnt_q + Cw'(1);
         end else if (rd_go) begin
            ram_cnt_q <= ram_cnt_q - Cw'(1);
         end
      end
   end

   // Head stage: park returning read data unless it is consumed straight away.
   always_ff @(posedge clk_i) begin
      if (flush) begin
         rd_pend_q  <= 1'b0;
         out_full_q <= 1'b0;
         out_q      <= '0;
      end else begin
         rd_pend_q <= rd_go;
         if (rd_pend_q && !pop) begin
            out_q      <= ram_rdata_i;
            out_full_q <= 1'b1;
         end else if (pop) begin
            out_full_q <= 1'b0;
         end
      end
   end

   a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
      ram_cnt_q <= Cw'(Depth));
   a_no_wr_full: assert property (@(posedge clk_i) disable iff (rst_i)
      !(wr_go && ram_cnt_q == Cw'(Depth)));
   a_no_rd_empty: assert property (@(posedge clk_i) disable iff (rst_i)
      !(rd_go && ram_cnt_q == '0));
   // A read only issues once the head drains, so both can never be occupied.
   a_head_excl: assert property (@(posedge clk_i) disable iff (rst_i)
      !(rd_pend_q && out_full_q));
   a_rdata_stable: assert property (@(posedge clk_i) disable iff (rst_i || clr_i)
      (rvalid && !bus.rready) |=> $stable(bus.rdata));

endmodule

// File: tb/tb_ram_1p_fifo_ctrl.sv
// Bench for ram_1p_fifo_ctrl: directed timing cases plus randomized traffic
// checked every cycle against a queue model of FIFO contents.
module tb_ram_1p_fifo_ctrl;
   localparam int unsigned W  = 32;
   localparam int unsigned D  = 4;
   localparam int unsigned Aw = $clog2(D);
   localparam int unsigned Cw = $clog2(D + 3);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;
   always #5 clk = ~clk;

   ram_1p_fifo_ctrl_if #(.Width(W)) bus ();

   logic [Cw-1:0] depth;
   logic          ram_req;
   logic          ram_write;
   logic [Aw-1:0] ram_addr;
   logic [W-1:0]  ram_wdata;
   logic [W-1:0]  ram_wmask;
   logic [W-1:0]  ram_rdata = '0;

   ram_1p_fifo_ctrl #(.Width(W), .Depth(D)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .clr_i       (clr),
      .bus         (bus),
      .depth_o     (depth),
      .ram_req_o   (ram_req),
      .ram_write_o (ram_write),
      .ram_addr_o  (ram_addr),
      .ram_wdata_o (ram_wdata),
      .ram_wmask_o (ram_wmask),
      .ram_rdata_i (ram_rdata)
   );

   // Single-port synchronous RAM model.
   logic [W-1:0] mem [D];
   always @(posedge clk) begin
      if (ram_req) begin
         if (ram_write) mem[ram_addr] <= ram_wdata;
         else           ram_rdata <= mem[ram_addr];
      end
   end

   int checks = 0;
   int errors = 0;

   function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endfunction

   // Reference model: FIFO contents plus expected RAM address sequences.
   logic [W-1:0] q [$];
   int wp = 0;
   int rp = 0;
   int stall = 0;

   always @(negedge clk) begin
      if (rst || clr) begin
         chk("flush_wready", bus.wready, 0);
         chk("flush_ram_req", ram_req, 0);
         q.delete();
         wp = 0;
         rp = 0;
         stall = 0;
      end else begin
         chk("depth", depth, q.size());
         if (bus.rvalid) begin
            if (q.size() == 0) chk("rvalid_when_empty", 1, 0);
            else               chk("rdata_order", bus.rdata, q[0]);
         end
         if (q.size() == D + 1) chk("full_wready", bus.wready, 0);
         stall = (q.size() != 0 && !bus.rvalid) ? stall + 1 : 0;
         if (stall > 1) chk("head_latency", stall, 1);
         chk("write_strobe", ram_req && ram_write, bus.wvalid && bus.wready);
         if (ram_req && ram_write) begin
            chk("wr_addr", ram_addr, wp);
            chk("wr_data", ram_wdata, bus.wdata);
            chk("wr_mask", ram_wmask, 32'hFFFF_FFFF);
            wp = (wp + 1) % D;
         end
         if (ram_req && !ram_write) begin
            chk("rd_addr", ram_addr, rp);
            chk("rd_blocks_wr", bus.wready, 0);
            rp = (rp + 1) % D;
         end
         if (!bus.wready && q.size() <= D) chk("stall_needs_read", ram_req && !ram_write, 1);
         if (bus.rvalid && bus.rready && q.size() != 0) void'(q.pop_front());
         if (bus.wvalid && bus.wready) q.push_back(bus.wdata);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Offer one word for up to 4 cycles; ok reports whether it was taken.
   task automatic push_word(input logic [W-1:0] d, output bit ok);
      bus.wvalid = 1'b1;
      bus.wdata  = d;
      ok = 1'b0;
      for (int n = 0; n < 4; n++) begin
         #2;
         if (bus.wready) ok = 1'b1;
         cyc();
         if (ok) break;
      end
      bus.wvalid = 1'b0;
   endtask

   initial begin
      bit ok;
      int accepted;
      int rpct;
      bus.wvalid = 1'b0;
      bus.wdata  = '0;
      bus.rready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #2;
      chk("reset_rvalid", bus.rvalid, 0);
      chk("reset_depth", depth, 0);
      chk("reset_ram_req", ram_req, 0);
      chk("reset_wready", bus.wready, 1);
      cyc();

      // Single push: write t, read t+1, data t+2, empty t+3.
      bus.wvalid = 1'b1;
      bus.wdata  = 32'hA5A5_A5A5;
      bus.rready = 1'b1;
      #2;
      chk("t1_wready", bus.wready, 1);
      chk("t1_write", ram_req && ram_write, 1);
      chk("t1_waddr", ram_addr, 0);
      cyc();
      bus.wvalid = 1'b0;
      #2;
      chk("t1_read", ram_req && !ram_write, 1);
      chk("t1_raddr", ram_addr, 0);
      chk("t1_rvalid_early", bus.rvalid, 0);
      chk("t1_depth1", depth, 1);
      cyc();
      #2;
      chk("t1_rvalid", bus.rvalid, 1);
      chk("t1_rdata", bus.rdata, 32'hA5A5_A5A5);
      cyc();
      #2;
      chk("t1_depth_end", depth, 0);
      chk("t1_rvalid_end", bus.rvalid, 0);
      cyc();

      // Fill to capacity with no pops, then stream out.
      bus.rready = 1'b0;
      accepted = 0;
      for (int k = 1; k <= 6; k++) begin
         push_word(W'(k), ok);
         if (ok) accepted++;
      end
      #2;
      chk("fill_accepted", accepted, 5);
      chk("fill_depth", depth, 5);
      chk("fill_wready", bus.wready, 0);
      chk("fill_head", bus.rdata, 1);
      cyc();
      bus.rready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         #2;
         chk("stream_rvalid", bus.rvalid, 1);
         chk("stream_rdata", bus.rdata, W'(i));
         cyc();
      end
      bus.rready = 1'b0;
      #2;
      chk("stream_done_rvalid", bus.rvalid, 0);
      chk("stream_done_depth", depth, 0);
      cyc();

      // Backpressure: head holds across a 3-cycle stall.
      push_word(32'h100, ok);
      push_word(32'h101, ok);
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("bp_rvalid", bus.rvalid, 1);
         chk("bp_hold", bus.rdata, 32'h100);
         cyc();
      end
      bus.rready = 1'b1;
      #2;
      chk("bp_pop0", bus.rdata, 32'h100);
      cyc();
      #2;
      chk("bp_pop1_valid", bus.rvalid, 1);
      chk("bp_pop1", bus.rdata, 32'h101);
      cyc();
      bus.rready = 1'b0;

      // Flush with a read in flight, then reuse.
      push_word(32'h21, ok);
      push_word(32'h22, ok);
      push_word(32'h23, ok);
      repeat (2) cyc();
      bus.rready = 1'b1;
      #2;
      chk("clr_read_issued", ram_req && !ram_write, 1);
      cyc();
      bus.rready = 1'b0;
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      #2;
      chk("clr_rvalid", bus.rvalid, 0);
      chk("clr_depth", depth, 0);
      chk("clr_ram_req", ram_req, 0);
      cyc();
      bus.wvalid = 1'b1;
      bus.wdata  = 32'h11;
      bus.rready = 1'b1;
      #2;
      chk("post_clr_wready", bus.wready, 1);
      cyc();
      bus.wvalid = 1'b0;
      cyc();
      #2;
      chk("post_clr_rvalid", bus.rvalid, 1);
      chk("post_clr_rdata", bus.rdata, 32'h11);
      cyc();

      // Randomized traffic with varying pop pressure and occasional flushes.
      rpct = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            case ($urandom_range(0, 2))
               0:       rpct = 10;
               1:       rpct = 50;
               default: rpct = 95;
            endcase
         end
         bus.wvalid = ($urandom_range(0, 99) < 60);
         bus.wdata  = $urandom;
         bus.rready = ($urandom_range(0, 99) < rpct);
         clr        = ($urandom_range(0, 299) == 0);
         cyc();
      end

      // Drain everything that is left.
      bus.wvalid = 1'b0;
      bus.rready = 1'b1;
      clr        = 1'b0;
      repeat (12) cyc();
      #2;
      chk("drain_depth", depth, 0);
      chk("drain_rvalid", bus.rvalid, 0);
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_1p_fifo_ctrl.md
Name: ram_1p_fifo_ctrl

Overview:
- FIFO controller that uses one external synchronous single-port RAM (one access per cycle, read data one cycle after req) as storage.
- Drives the RAM's req/write/addr/wdata/wmask and consumes its read data.
- Presents valid/ready push and pop interfaces, and a one-entry head stage so pops can stream at one per cycle.
- Used in front of the core's TX/RX/command queues wherever a register-based FIFO is too large.

Parameters:
- Width, 32, data word width in bits.
- Depth, 64, RAM entries; any value >= 2, not necessarily a power of two.
- Aw, $clog2(Depth), localparam: RAM address width.
- Cw, $clog2(Depth+3), localparam: occupancy counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- clr_i  in  1  synchronous flush; same effect as reset on FIFO state.
- wvalid_i  in  1  push request.
- wready_o  out  1  push accepted when wvalid_i && wready_o.
- wdata_i  in  Width  push data.
- rvalid_o  out  1  head entry valid.
- rready_i  in  1  pop; entry consumed when rvalid_o && rready_i.
- rdata_o  out  Width  head entry data.
- depth_o  out  Cw  total entries held.
- ram_req_o  out  1  RAM access strobe.
- ram_write_o  out  1  1 = write, 0 = read.
- ram_addr_o  out  Aw  RAM address.
- ram_wdata_o  out  Width  RAM write data (= wdata_i).
- ram_wmask_o  out  Width  always all ones.
- ram_rdata_i  in  Width  RAM read data, valid the cycle after a read access.

Behaviour:
- State: wr_ptr and rd_ptr (Aw bits), ram_cnt (0..Depth), rd_pend (read issued last cycle), out_full and out_q (head register).
- Reset / clr_i: all state cleared to 0 at the clock edge.
  - Resulting outputs: wready_o=0 while rst_i or clr_i is high, rvalid_o=0, depth_o=0, ram_req_o=0.
  - While rst_i or clr_i is high, no RAM access is issued and push/pop are ignored.
  - An in-flight read is discarded; RAM contents are left unchanged.
- Head stage:
  - rvalid_o = out_full || rd_pend.
  - rdata_o = out_full ? out_q : ram_rdata_i.
- pop = rvalid_o && rready_i.
- Read issue (rd_go) = ram_cnt != 0 && (!rvalid_o || pop). Reads have priority over writes.
- Write issue (wr_go) = wvalid_i && wready_o, with wready_o = ram_cnt < Depth && !rd_go.
  - wready_o depends combinationally on rready_i. This is allowed, but wready_o must not depend on wvalid_i.
- RAM drive:
  - ram_req_o = rd_go || wr_go.
  - ram_write_o = wr_go.
  - ram_addr_o = wr_go ? wr_ptr : rd_ptr.
  - Never both rd_go and wr_go in one cycle.
- Pointers: increment on their respective go and wrap from Depth-1 to 0.
- ram_cnt: +1 on wr_go, -1 on rd_go. Never both.
- Next-cycle head state:
  - rd_pend <= rd_go.
  - If rd_pend && !pop: out_q <= ram_rdata_i, out_full <= 1.
  - Else if pop: out_full <= 0.
  - If rd_pend && pop with out_full=1: impossible, because rd_go requires the head to drain. Add an assertion.
- depth_o = ram_cnt + out_full + rd_pend, registered-state based with no combinational input paths.
- Latency:
  - Push to an empty FIFO at cycle t gives rvalid_o=1 at t+2 (write t, read t+1, data t+2).
  - Sustained pops with rready_i=1 and no pushes: one entry per cycle.
- Capacity: Depth+1 (RAM plus head). A full FIFO has depth_o=Depth+1 and wready_o=0.
- Contention: when rd_go and wvalid_i coincide, the write stalls one cycle (wready_o=0). No data is lost or reordered.
- Ordering: strict FIFO. A read never targets an address written in the same cycle; the single port makes this guaranteed.
- Assertions:
  - ram_cnt <= Depth.
  - No wr_go when ram_cnt == Depth.
  - No rd_go when ram_cnt == 0.
  - rdata_o stable while rvalid_o && !rready_i.

Test Plan:
- Single push of 0xA5A5A5A5 at cycle 0, rready_i=1 → RAM write at 0 addr 0, read at 1, rvalid_o=1 with rdata_o=0xA5A5A5A5 at 2, depth_o back to 0 at 3.
- Depth=4, rready_i=0, push 1..6 → first 5 accepted. wready_o=0 once depth_o=5. Then rready_i=1 pops 1,2,3,4,5 in order on 5 consecutive cycles, rvalid_o=0 afterwards.
- Depth=4, 20 pushes of incrementing data with continuous interleaved pops → pointers wrap (addr sequence 0,1,2,3,0…). Output order matches input, no gaps beyond contention stalls.
- Push held valid while the head drains each cycle → wready_o=0 exactly in the rd_go cycles. Every accepted word is popped once, in order.
- Backpressure: rready_i=0 during rd_pend → out_q captures ram_rdata_i. rdata_o holds its value across a 3-cycle stall, and the next pop returns the next entry.
- Fill 3 entries, assert clr_i in the same cycle a read is issued → next cycle rvalid_o=0, depth_o=0, ram_req_o=0. A subsequent push of 0x11 then pops 0x11 with latency 2.
